// File: rtl/lsu_bus_ctrl_if.sv
// lsu_bus_ctrl_if: word-wide data-memory bus between the LSU and memory.
// master drives req/we/addr/wdata/wstrb; slave returns rdata and ack.
interface lsu_bus_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_wdata, bus_wstrb,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_wdata, bus_wstrb,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: multi-cycle load/store unit, IDLE -> REQ -> DONE.
// Ports: clk, reset (sync, high); core side MemRead, MemWrite, funct3,
// Addr, WriteData -> ReadData, Stall, Fault; bus via lsu_bus_ctrl_if.master.
module lsu_bus_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  lsu_bus_ctrl_if.master bus
);

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [CW-1:0] cnt_q;
  logic        fault_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  f3_q;

  logic        start;
  logic        bad;
  logic        illegal;
  logic        misal;
  logic        tout;
  logic [3:0]  strb;
  logic [31:0] wd;
  logic        is_b;
  logic        is_h;
  logic        is_w;

  assign start = MemRead | MemWrite;
  assign is_b  = (funct3[1:0] == 2'b00);
  assign is_h  = (funct3[1:0] == 2'b01);
  assign is_w  = (funct3[1:0] == 2'b10);

  // Unsigned variants (bit 2) exist only for loads.
  assign illegal = (funct3[1:0] == 2'b11)
                 | (funct3 == 3'b110)
                 | (MemWrite & funct3[2]);
  assign misal = (is_h & Addr[0])
               | (is_w & (Addr[1:0] != 2'b00));
  assign bad  = illegal | misal;
  assign tout = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    strb = 4'b0000;
    wd   = WriteData;
    unique case (1'b1)
      is_b: begin
        strb = 4'b0001 << Addr[1:0];
        wd   = {4{WriteData[7:0]}};
      end
      is_h: begin
        strb = Addr[1] ? 4'b1100 : 4'b0011;
        wd   = {2{WriteData[15:0]}};
      end
      default: strb = 4'b1111;
    endcase
  end

  function automatic logic [31:0] ext(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  a
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    unique case (1'b1)
      (f3 == 3'b000): r = {{24{b[7]}}, b};
      (f3 == 3'b100): r = {24'h0, b};
      (f3 == 3'b001): r = {{16{h[15]}}, h};
      (f3 == 3'b101): r = {16'h0, h};
      default:        r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    Stall       = 1'b0;
    Fault       = 1'b0;
    bus.bus_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          Stall   = 1'b1;
          state_d = bad ? DONE : REQ;
        end
      end
      REQ: begin
        Stall       = 1'b1;
        bus.bus_req = 1'b1;
        if (bus.bus_ack || tout)
          state_d = DONE;
      end
      DONE: begin
        Fault   = fault_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && bad) begin
            fault_q <= 1'b1;
            rdata_q <= '0;
          end else if (start) begin
            fault_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= Addr;
            we_q    <= MemWrite;
            wdata_q <= wd;
            wstrb_q <= MemWrite ? strb : 4'b0000;
            f3_q    <= funct3;
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            rdata_q <= we_q ? 32'h0
                     : ext(bus.bus_rdata, f3_q, addr_q[1:0]);
          end else if (tout) begin
            fault_q <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ReadData      = rdata_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = {addr_q[31:2], 2'b00};
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed-vector bench for lsu_bus_ctrl.
// Bus slave is modelled inline; expected values are hand-computed.
module tb_lsu_bus_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Fault;

  int checks = 0;
  int failures = 0;

  int          stalls;
  int          reqs;
  logic        done_seen;
  logic        unstable;
  logic [31:0] r_data;
  logic        r_flt;
  logic [31:0] q_addr;
  logic [31:0] q_wdata;
  logic [3:0]  q_wstrb;
  logic        q_we;

  lsu_bus_ctrl_if bus ();

  lsu_bus_ctrl #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Fault     (Fault),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one memory instruction; ack comes after waitn REQ cycles.
  task automatic access(
    input logic        wr,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wdat,
    input logic [31:0] rd,
    input int          waitn
  );
    MemWrite      = wr;
    MemRead       = !wr;
    funct3        = f3;
    Addr          = a;
    WriteData     = wdat;
    bus.bus_rdata = rd;
    bus.bus_ack   = 1'b0;
    stalls    = 0;
    reqs      = 0;
    done_seen = 1'b0;
    unstable  = 1'b0;
    r_data    = '0;
    r_flt     = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      #1;
      if (bus.bus_req) begin
        reqs++;
        if (reqs == 1) begin
          q_addr  = bus.bus_addr;
          q_wdata = bus.bus_wdata;
          q_wstrb = bus.bus_wstrb;
          q_we    = bus.bus_we;
        end else if ({q_addr, q_wdata, q_wstrb, q_we} !==
                     {bus.bus_addr, bus.bus_wdata,
                      bus.bus_wstrb, bus.bus_we}) begin
          unstable = 1'b1;
        end
      end
      if (!Stall) begin
        done_seen = 1'b1;
        r_data    = ReadData;
        r_flt     = Fault;
      end else begin
        stalls++;
        bus.bus_ack = bus.bus_req && (reqs > waitn);
        @(posedge clk);
      end
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("bus_stable", 32'(unstable), 32'd0);
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    bus.bus_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_stall", 32'(Stall), 32'd0);
    chk("idle_fault", 32'(Fault), 32'd0);
    chk("idle_req", 32'(bus.bus_req), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    funct3        = 3'b000;
    Addr          = '0;
    WriteData     = '0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_req", 32'(bus.bus_req), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);
    chk("rst_rdata", ReadData, 32'h0);

    // lw 0x100, zero-wait ack
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    chk("lw_data", r_data, 32'hDEADBEEF);
    chk("lw_stalls", 32'(stalls), 32'd2);
    chk("lw_fault", 32'(r_flt), 32'd0);
    chk("lw_reqs", 32'(reqs), 32'd1);
    chk("lw_addr", q_addr, 32'h100);
    chk("lw_wstrb", 32'(q_wstrb), 32'd0);
    chk("lw_we", 32'(q_we), 32'd0);

    // byte/half extraction from 0x80123456
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0);
    chk("lb_103", r_data, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0);
    chk("lbu_103", r_data, 32'h00000080);
    access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0);
    chk("lhu_102", r_data, 32'h00008012);
    access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80123456, 0);
    chk("lh_102", r_data, 32'hFFFF8012);
    access(1'b0, 3'b001, 32'h100, 32'h0, 32'h80123456, 0);
    chk("lh_100", r_data, 32'h00003456);
    access(1'b0, 3'b000, 32'h101, 32'h0, 32'h80123456, 2);
    chk("lb_101", r_data, 32'h00000034);
    chk("lb_101_stalls", 32'(stalls), 32'd4);

    // stores
    access(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'hFFFFFFFF, 0);
    chk("sb_we", 32'(q_we), 32'd1);
    chk("sb_addr", q_addr, 32'h200);
    chk("sb_wstrb", 32'(q_wstrb), 32'b0010);
    chk("sb_wdata", q_wdata, 32'hA5A5A5A5);
    chk("sb_rdata", r_data, 32'h0);
    access(1'b1, 3'b001, 32'h202, 32'h1234BEEF, 32'h0, 1);
    chk("sh_wstrb", 32'(q_wstrb), 32'b1100);
    chk("sh_wdata", q_wdata, 32'hBEEFBEEF);
    chk("sh_stable_reqs", 32'(reqs), 32'd2);
    access(1'b1, 3'b010, 32'h300, 32'h11223344, 32'h0, 0);
    chk("sw_wstrb", 32'(q_wstrb), 32'b1111);
    chk("sw_wdata", q_wdata, 32'h11223344);
    chk("sw_addr", q_addr, 32'h300);

    // fault path: misaligned and illegal
    access(1'b0, 3'b010, 32'h102, 32'h0, 32'h12345678, 0);
    chk("lw_mis_fault", 32'(r_flt), 32'd1);
    chk("lw_mis_reqs", 32'(reqs), 32'd0);
    chk("lw_mis_data", r_data, 32'h0);
    chk("lw_mis_stalls", 32'(stalls), 32'd1);
    access(1'b0, 3'b011, 32'h100, 32'h0, 32'h12345678, 0);
    chk("f3_011_fault", 32'(r_flt), 32'd1);
    chk("f3_011_reqs", 32'(reqs), 32'd0);
    access(1'b1, 3'b100, 32'h100, 32'h5A, 32'h0, 0);
    chk("sbu_fault", 32'(r_flt), 32'd1);
    chk("sbu_reqs", 32'(reqs), 32'd0);
    access(1'b0, 3'b001, 32'h101, 32'h0, 32'h12345678, 0);
    chk("lh_mis_fault", 32'(r_flt), 32'd1);

    // timeout, then a late ack
    access(1'b0, 3'b010, 32'h400, 32'h0, 32'h55555555, 100);
    chk("to_reqs", 32'(reqs), 32'd16);
    chk("to_fault", 32'(r_flt), 32'd1);
    chk("to_stalls", 32'(stalls), 32'd17);
    chk("to_data", r_data, 32'h0);
    bus.bus_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("late_ack_req", 32'(bus.bus_req), 32'd0);
    chk("late_ack_stall", 32'(Stall), 32'd0);
    chk("late_ack_fault", 32'(Fault), 32'd0);
    bus.bus_ack = 1'b0;

    // reset in the third REQ cycle
    MemRead = 1'b1;
    funct3  = 3'b010;
    Addr    = 32'h500;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_req", 32'(bus.bus_req), 32'd1);
    reset   = 1'b1;
    MemRead = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_req", 32'(bus.bus_req), 32'd0);
    chk("mid_rst_stall", 32'(Stall), 32'd0);
    reset         = 1'b0;
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    chk("post_rst_req", 32'(bus.bus_req), 32'd0);
    chk("post_rst_fault", 32'(Fault), 32'd0);
    chk("post_rst_data", ReadData, 32'h0);
    bus.bus_ack = 1'b0;
    @(posedge clk);
    #1;

    // normal access after reset recovery
    access(1'b0, 3'b010, 32'h600, 32'h0, 32'h0BADF00D, 0);
    chk("rec_data", r_data, 32'h0BADF00D);
    chk("rec_stalls", 32'(stalls), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
